// File: rtl/logic_pkg.sv
// Shared encodings for the bitwise logic engine: operation select and FSM states.
package logic_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_MAJ = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational per-chunk operator: y = f(op, a, b, c) with optional bitwise inversion.
module logic_slice
    import logic_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [CHUNK-1:0] c,
    input  op_e              op,
    input  logic             inv,
    output logic [CHUNK-1:0] y
);

    logic [CHUNK-1:0] f;

    always_comb begin
        f = '0;
        case (op)
            OP_OR:   f = a | b;
            OP_AND:  f = a & b;
            OP_XOR:  f = a ^ b;
            OP_MAJ:  f = (a & b) | (a & c) | (b & c);
            default: f = '0;
        endcase
        y = f ^ {CHUNK{inv}};
    end

endmodule

// File: rtl/bitwise_logic_engine.sv
// Multi-cycle bitwise engine: computes OR/AND/XOR/MAJ over WIDTH bits, CHUNK bits per cycle,
// LSB chunk first, from operands captured at accept.
module bitwise_logic_engine
    import logic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             inv,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("bitwise_logic_engine: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
    state_e           state, state_nx;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q, b_q, c_q, result_q;
    op_e              op_q;
    logic             inv_q;
    logic             last_chunk;
    logic [CHUNK-1:0] slice_y;

    assign last_chunk = (k == KW'(NCH - 1));

    logic_slice #(.CHUNK(CHUNK)) u_slice (
        .a   (a_q[int'(k)*CHUNK +: CHUNK]),
        .b   (b_q[int'(k)*CHUNK +: CHUNK]),
        .c   (c_q[int'(k)*CHUNK +: CHUNK]),
        .op  (op_q),
        .inv (inv_q),
        .y   (slice_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid)   state_nx = S_BUSY;
            S_BUSY:  if (last_chunk) state_nx = S_DONE;
            S_DONE:  if (out_ready)  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            op_q     <= OP_OR;
            inv_q    <= 1'b0;
            k        <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        c_q      <= c;
                        op_q     <= op_e'(op);
                        inv_q    <= inv;
                        k        <= '0;
                        result_q <= '0;
                    end
                end
                S_BUSY: begin
                    result_q[int'(k)*CHUNK +: CHUNK] <= slice_y;
                    k <= last_chunk ? '0 : k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_BUSY) || (state == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_bitwise_logic_engine.sv
// Self-checking bench for bitwise_logic_engine (WIDTH=16 with CHUNK=4 and CHUNK=16).
module tb_bitwise_logic_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, inv = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0, b = '0, c = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] result;

  logic        w_in_valid = 1'b0, w_out_ready = 1'b0, w_inv = 1'b0;
  logic [1:0]  w_op = 2'b00;
  logic [15:0] w_a = '0, w_b = '0, w_c = '0;
  logic        w_in_ready, w_out_valid, w_busy;
  logic [15:0] w_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  bitwise_logic_engine #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .inv(inv),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  bitwise_logic_engine #(.WIDTH(16), .CHUNK(16)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op), .inv(w_inv),
    .a(w_a), .b(w_b), .c(w_c), .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
    .busy(w_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: per-bit count of ones decides the output bit
  function automatic logic [15:0] model(input logic [1:0] o, input logic iv,
                                        input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      int ab;
      int abc;
      ab  = int'(x[i]) + int'(y[i]);
      abc = ab + int'(z[i]);
      case (o)
        2'b00: r[i] = (ab >= 1);
        2'b01: r[i] = (ab == 2);
        2'b10: r[i] = (ab == 1);
        default: r[i] = (abc >= 2);
      endcase
      r[i] = r[i] ^ iv;
    end
    return r;
  endfunction

  // driver: present one request, scramble inputs after accept, wait for out_valid
  task automatic issue(input logic [1:0] o, input logic iv, input logic [15:0] ia,
                       input logic [15:0] ib, input logic [15:0] ic,
                       output int lat, output bit saw_ready);
    op = o; inv = iv; a = ia; b = ib; c = ic;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    op = 2'($urandom); inv = 1'($urandom);
    out_ready = 1'($urandom);
    lat = 0; saw_ready = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
      out_ready = 1'b0;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h, required 1 0 0 0000",
               in_ready, out_valid, busy, result);
    end
    n_checks++;
    if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_busy !== 1'b0 || w_result !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state_w: in_ready=%b out_valid=%b busy=%b result=%h, required 1 0 0 0000",
               w_in_ready, w_out_valid, w_busy, w_result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_or();
    int lat; bit saw;
    issue(2'b00, 1'b0, 16'h00F0, 16'h0F01, 16'h0000, lat, saw);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL or_latency: got %0d, required 4", lat); end
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL or_in_ready: in_ready seen 1 while busy, required 0"); end
    n_checks++;
    if (result !== 16'h0FF1) begin n_fail++; $display("FAIL or_result: got %h, required 0ff1", result); end
    release_result();
    n_checks++;
    if (in_ready !== 1'b1 || result !== 16'h0FF1) begin
      n_fail++;
      $display("FAIL or_idle_hold: in_ready=%b result=%h, required 1 0ff1", in_ready, result);
    end
  endtask

  task automatic test_maj();
    int lat; bit saw;
    issue(2'b11, 1'b0, 16'hFF00, 16'hF0F0, 16'hCCCC, lat, saw);
    n_checks++;
    if (result !== 16'hFCC0) begin n_fail++; $display("FAIL maj_result: got %h, required fcc0", result); end
    release_result();
    issue(2'b11, 1'b1, 16'hFF00, 16'hF0F0, 16'hCCCC, lat, saw);
    n_checks++;
    if (result !== 16'h033F) begin n_fail++; $display("FAIL maj_inv_result: got %h, required 033f", result); end
    release_result();
  endtask

  task automatic test_xor_hold();
    int lat; bit saw;
    issue(2'b10, 1'b0, 16'h1234, 16'hFFFF, 16'h0000, lat, saw);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (result !== 16'hEDCB || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL xor_hold[%0d]: result=%h out_valid=%b in_ready=%b, required edcb 1 0",
                 i, result, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    release_result();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL xor_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    op = 2'b01; inv = 1'b0; a = 16'hAAAA; b = 16'h0FF0; c = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk); #1;
    op = 2'b00; inv = 1'b1; a = 16'h5555; b = 16'hFFFF;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (result !== 16'h0AA0 || lat !== 4) begin
      n_fail++;
      $display("FAIL ignore_busy: result=%h latency=%0d, required 0aa0 4", result, lat);
    end
    // in_valid still high across the DONE->IDLE edge must not be accepted there
    release_result();
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_accept_leaving_done: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int lat; bit saw; bit pulse;
    op = 2'b10; inv = 1'b0; a = 16'hFFFF; b = 16'h0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: in_ready=%b out_valid=%b busy=%b result=%h, required 1 0 0 0000",
               in_ready, out_valid, busy, result);
    end
    #1 rst = 1'b0;
    pulse = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulse = 1'b1;
    end
    n_checks++;
    if (pulse) begin n_fail++; $display("FAIL reset_no_valid: out_valid pulsed after reset, required 0"); end
    issue(2'b00, 1'b0, 16'h1200, 16'h0034, 16'h0000, lat, saw);
    n_checks++;
    if (result !== 16'h1234 || lat !== 4) begin
      n_fail++;
      $display("FAIL after_reset: result=%h latency=%0d, required 1234 4", result, lat);
    end
    release_result();
  endtask

  task automatic test_chunk_full();
    int lat;
    w_op = 2'b00; w_inv = 1'b0; w_a = 16'h8001; w_b = 16'h0100;
    w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0; w_a = 16'hFFFF;
    lat = 0;
    while (!w_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (w_result !== 16'h8101 || lat !== 1) begin
      n_fail++;
      $display("FAIL chunk16: result=%h latency=%0d, required 8101 1", w_result, lat);
    end
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
    n_checks++;
    if (w_in_ready !== 1'b1) begin n_fail++; $display("FAIL chunk16_idle: in_ready=%b, required 1", w_in_ready); end
  endtask

  task automatic test_random();
    int lat; bit saw;
    logic [1:0] o; logic iv; logic [15:0] ra, rb, rc, exp;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom); iv = 1'($urandom);
      ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
      exp_q.push_back(model(o, iv, ra, rb, rc));
      issue(o, iv, ra, rb, rc, lat, saw);
      for (int d = $urandom_range(0, 2); d > 0; d--) begin
        @(posedge clk); #1;
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (result !== exp || lat !== 4 || saw || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL random[%0d]: op=%0d inv=%0d result=%h latency=%0d out_valid=%b, required %h 4 1",
                 n, o, iv, result, lat, out_valid, exp);
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_or();
    test_maj();
    test_xor_hold();
    test_ignore_busy();
    test_reset_mid_busy();
    test_chunk_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
